// File: rtl/checksum_arbiter.sv
// Round-robin arbiter sharing one combinational checksum unit among NUM_REQ flit
// requesters; each accepted flit is stamped or verified into a registered output slot.
package types;
  typedef struct packed {
    logic [7:0]  header;
    logic [31:0] payload;
    logic [7:0]  checksum;
  } flit_t;
endpackage

module calculate_checksum_comb (
  input  types::flit_t i_flit,
  output logic [7:0]   o_checksum,
  output logic         o_is_valid,
  output types::flit_t o_flit
);
  logic [7:0] w_sum;

  // One's complement of the modulo-256 byte sum over header and payload.
  assign w_sum = i_flit.header + i_flit.payload[31:24] + i_flit.payload[23:16]
               + i_flit.payload[15:8] + i_flit.payload[7:0];
  assign o_checksum = ~w_sum;
  assign o_is_valid = (i_flit.checksum == o_checksum);

  always_comb begin
    o_flit          = i_flit;
    o_flit.checksum = o_checksum;
  end
endmodule

module checksum_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_mode,
  input  types::flit_t [NUM_REQ-1:0] req_flit,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output types::flit_t               out_flit,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  input  logic                       out_ready,
  output logic                       err_valid,
  output logic [$clog2(NUM_REQ)-1:0] err_src,
  output logic [CNT_W-1:0]           err_count,
  input  logic                       err_clr
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] r_ptr;
  logic             r_out_valid;
  types::flit_t     r_out_flit;
  logic [IDX_W-1:0] r_out_src;
  logic             r_err_valid;
  logic [IDX_W-1:0] r_err_src;
  logic [CNT_W-1:0] r_err_count;

  logic [IDX_W-1:0] w_rot_idx [NUM_REQ];
  logic             w_found;
  logic [IDX_W-1:0] w_gidx;
  logic             w_can_accept;
  logic             w_accept;
  logic             w_mode;
  logic             w_drop;
  logic             w_load;
  logic [IDX_W-1:0] w_ptr_next;
  logic [7:0]       w_checksum;
  logic             w_is_valid;
  types::flit_t     w_stamped;

  // w_rot_idx[k] is the requester examined k-th in the search starting at r_ptr.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [IDX_W:0] w_sum;
    assign w_sum = {1'b0, r_ptr} + (IDX_W+1)'(gi);
    assign w_rot_idx[gi] = (w_sum >= (IDX_W+1)'(NUM_REQ))
                         ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                         : w_sum[IDX_W-1:0];
  end

  // Scan from the back so the candidate closest to r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[w_rot_idx[k]]) begin
        w_found = 1'b1;
        w_gidx  = w_rot_idx[k];
      end
    end
  end

  assign w_can_accept = !r_out_valid || out_ready;
  assign w_accept     = w_found && w_can_accept && !rst;
  assign req_ready    = w_accept ? (NUM_REQ'(1) << w_gidx) : '0;

  calculate_checksum_comb u_cs (
    .i_flit     (req_flit[w_gidx]),
    .o_checksum (w_checksum),
    .o_is_valid (w_is_valid),
    .o_flit     (w_stamped)
  );

  assign w_mode     = req_mode[w_gidx];
  assign w_drop     = w_accept && w_mode && !w_is_valid;
  assign w_load     = w_accept && !w_drop;
  assign w_ptr_next = (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_src   <= '0;
      r_err_valid <= 1'b0;
      r_err_src   <= '0;
      r_err_count <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_flit  <= w_mode ? req_flit[w_gidx] : w_stamped;
        r_out_src   <= w_gidx;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) r_ptr <= w_ptr_next;
      r_err_valid <= w_drop;
      if (w_drop) r_err_src <= w_gidx;
      // A clear coinciding with a drop leaves exactly that drop counted.
      if (err_clr)                          r_err_count <= w_drop ? CNT_W'(1) : '0;
      else if (w_drop && r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_flit  = r_out_flit;
  assign out_src   = r_out_src;
  assign err_valid = r_err_valid;
  assign err_src   = r_err_src;
  assign err_count = r_err_count;
endmodule

// File: tb/tb_checksum_arbiter.sv
// Randomized + directed bench for checksum_arbiter: a spec-level model predicts
// grants and pushes expected outputs/errors into queues drained by a monitor.
`timescale 1ns/1ps
module tb_checksum_arbiter;
  import types::*;

  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_mode, req_ready;
  flit_t [N-1:0] req_flit;
  logic          out_valid, out_ready;
  flit_t         out_flit;
  logic [1:0]    out_src, err_src;
  logic          err_valid, err_clr;
  logic [CW-1:0] err_count;

  int checks = 0;
  int failures = 0;

  typedef struct { flit_t f; int src; } out_t;
  out_t out_q[$];
  int   err_q[$];

  int   m_ptr = 0;
  int   m_cnt = 0;
  bit   m_ov  = 1'b0;
  bit   m_err = 1'b0;
  logic [N-1:0] acc;

  checksum_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mode(req_mode), .req_flit(req_flit), .req_ready(req_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_src(out_src), .out_ready(out_ready),
    .err_valid(err_valid), .err_src(err_src), .err_count(err_count), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_cs(flit_t f);
    int s = f.header;
    for (int b = 0; b < 4; b++) s += (f.payload >> (8 * b)) & 32'hFF;
    return 8'(255 - (s % 256));
  endfunction

  // Requester that should be granted right now, or -1.
  function automatic int pick();
    if (rst) return -1;
    if (m_ov && !out_ready) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    int    g;
    flit_t f;
    bit    drop;
    out_t  o;
    drop = 1'b0;
    if (rst) begin
      m_ptr = 0; m_ov = 1'b0; m_cnt = 0; m_err = 1'b0;
      out_q.delete();
      err_q.delete();
      return;
    end
    g = pick();
    if (g >= 0) begin
      f = req_flit[g];
      m_ptr = (g + 1) % N;
      if (req_mode[g] && f.checksum != ref_cs(f)) begin
        drop = 1'b1;
        err_q.push_back(g);
        m_ov = 1'b0;
      end else begin
        if (!req_mode[g]) f.checksum = ref_cs(f);
        o.f = f;
        o.src = g;
        out_q.push_back(o);
        m_ov = 1'b1;
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    m_err = drop;
    if (err_clr) m_cnt = drop ? 1 : 0;
    else if (drop && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic model_check();
    int g;
    g = pick();
    chk("req_ready", req_ready, (g >= 0) ? (64'(1) << g) : 64'(0));
    chk("out_valid", out_valid, m_ov);
    chk("err_valid", err_valid, m_err);
    chk("err_count", err_count, m_cnt);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_check();
    end
  end

  // Monitor: compares whatever the DUT presents against the head of each queue.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (out_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL out_unexpected actual=flit 0x%0h src %0d required=no pending flit", out_flit, out_src);
        end else begin
          chk("out_flit", out_flit, out_q[0].f);
          chk("out_src", out_src, out_q[0].src);
          if (out_ready) void'(out_q.pop_front());
        end
      end
      if (err_valid === 1'b1) begin
        if (err_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL err_unexpected actual=err_src %0d required=no pending drop", err_src);
        end else begin
          chk("err_src", err_src, err_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  function automatic flit_t mk(bit bad);
    flit_t f;
    f.header   = 8'($urandom);
    f.payload  = $urandom;
    f.checksum = ref_cs(f) ^ {7'd0, bad};
    return f;
  endfunction

  task automatic set_req(int i, bit mode, flit_t f);
    req_valid[i] = 1'b1;
    req_mode[i]  = mode;
    req_flit[i]  = f;
  endtask

  task automatic send(int i, bit mode, flit_t f);
    int n = 0;
    set_req(i, mode, f);
    do begin
      tick();
      n++;
    end while (!acc[i] && n < 20);
    chk("send_accepted", acc[i], 1'b1);
  endtask

  task automatic wait_idle(int limit);
    int n = 0;
    while (req_valid != '0 && n < limit) begin
      tick();
      n++;
    end
    chk("drain_req_valid", req_valid, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    flit_t f;
    rst = 1'b1; out_ready = 1'b1; err_clr = 1'b0; req_mode = '0;
    for (int i = 0; i < N; i++) req_flit[i] = mk(1'b0);
    req_valid = '1;
    repeat (3) tick();
    chk("rst_out_flit", out_flit, '0);
    chk("rst_out_src", out_src, '0);
    chk("rst_err_src", err_src, '0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Single stamp from requester 2.
    f = mk(1'b0);
    f.checksum = 8'hFF;
    send(2, 1'b0, f);
    repeat (2) tick();

    // All requesters continuously valid.
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i]) set_req(i, 1'($urandom_range(0, 1)), mk(1'b0));
      tick();
    end
    wait_idle(10);
    repeat (2) tick();

    // Verify pass, then the same flit with a corrupted checksum.
    f = mk(1'b0);
    send(1, 1'b1, f);
    f.checksum ^= 8'h01;
    send(1, 1'b1, f);
    repeat (2) tick();

    // Counter saturation and clear.
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    for (int c = 0; c < 5; c++) send(1, 1'b1, mk(1'b1));
    err_clr = 1'b1; send(1, 1'b1, mk(1'b1)); err_clr = 1'b0;
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    tick();

    // Backpressure with a held flit.
    send(2, 1'b0, mk(1'b0));
    out_ready = 1'b0;
    set_req(0, 1'b0, mk(1'b0));
    set_req(3, 1'b1, mk(1'b0));
    repeat (5) tick();
    out_ready = 1'b1;
    wait_idle(10);
    repeat (2) tick();

    // Reset while a flit is held and the pointer sits at 2.
    send(0, 1'b0, mk(1'b0));
    send(1, 1'b1, mk(1'b0));
    rst = 1'b1;
    set_req(1, 1'b0, mk(1'b0));
    set_req(3, 1'b1, mk(1'b0));
    tick();
    rst = 1'b0;
    wait_idle(10);
    repeat (2) tick();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), mk($urandom_range(0, 2) == 0));
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    wait_idle(20);
    repeat (3) tick();
    chk("out_q_empty", out_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/checksum_arbiter.md
Name: checksum_arbiter

Overview:
- Shares one combinational checksum unit (calculate_checksum_comb) among NUM_REQ flit requesters using round-robin arbitration.
- Each accepted flit is handled in one of two modes:
  - stamp: the checksum field is overwritten with the computed value.
  - verify: the flit is forwarded unchanged if its checksum matches, otherwise it is dropped.
- Results go into a single registered output slot with a valid/ready handshake.
- The block sits between the router input ports and the link/transmit stage. It also reports checksum errors and counts them.

Parameters:
- NUM_REQ, 4, number of requesters (at least 2). IDX_W = $clog2(NUM_REQ) is a localparam.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester flit valid.
- req_mode  in  NUM_REQ  per-requester mode: 0 = stamp, 1 = verify.
- req_flit  in  NUM_REQ x types::flit_t  per-requester flit.
- req_ready  out  NUM_REQ  one-hot grant/accept, at most one bit high.
- out_valid  out  1  output slot holds a flit.
- out_flit  out  types::flit_t  output flit.
- out_src  out  IDX_W  index of the requester that produced out_flit.
- out_ready  in  1  downstream accepts out_flit.
- err_valid  out  1  one-cycle pulse: a verify-mode flit was dropped.
- err_src  out  IDX_W  requester index of the dropped flit; valid only while err_valid = 1.
- err_count  out  CNT_W  saturating count of dropped flits.
- err_clr  in  1  synchronous clear of err_count.

Behaviour:
- Reset values:
  - out_valid = 0, out_flit = 0, out_src = 0.
  - err_valid = 0, err_src = 0, err_count = 0.
  - Round-robin pointer ptr = 0.
  - req_ready is forced to 0 while rst = 1.
- Slot availability: can_accept = !out_valid || out_ready, evaluated combinationally.
- Arbitration (combinational, same cycle):
  - If can_accept is high, grant the first i with req_valid[i] = 1, searching ptr, ptr+1, … with wrap modulo NUM_REQ.
  - req_ready[i] = 1 only for the granted i.
  - An accept is req_valid[i] && req_ready[i].
  - req_ready never depends on whether the flit will be dropped.
- Pointer update: after an accept from i, ptr <= (i+1) mod NUM_REQ. With no accept, ptr holds.
- Requester rules:
  - A requester holds req_valid, req_flit and req_mode stable until accepted.
  - A non-granted valid requester is never lost.
  - No requester waits more than NUM_REQ-1 accepts.
- Datapath: the granted req_flit drives the checksum unit, producing checksum, is_valid and the restamped flit. Latency is 1 cycle from accept to the output register or error pulse.
- Accepted stamp-mode flit: next cycle out_valid = 1, out_flit = the restamped flit, out_src = i.
- Accepted verify-mode flit with is_valid = 1: next cycle out_valid = 1, out_flit = req_flit (bit-identical), out_src = i.
- Accepted verify-mode flit with is_valid = 0:
  - The output slot is not loaded. out_valid becomes 0 if the old flit drained this cycle, otherwise it keeps its old value.
  - err_valid = 1 for exactly one cycle, with err_src = i.
  - err_count increments, saturating at 2^CNT_W-1.
- Output hold: if out_valid && !out_ready, out_flit and out_src stay stable and no grant is issued.
- Full throughput: out_valid && out_ready together with a new accept in the same cycle reloads the slot back-to-back, giving 1 flit per cycle sustained.
- Drain without accept: out_valid && out_ready with no accept sets out_valid <= 0.
- err_clr:
  - err_count <= 0.
  - If a drop occurs in the same cycle, err_count <= 1.
  - err_clr does not affect err_valid.
- Reset mid-operation:
  - Any held output flit is discarded and any pending error pulse is cancelled.
  - ptr returns to 0.
  - Requesters retain their flits and are re-arbitrated from index 0 after reset deasserts.
- Idle: with no req_valid, all req_ready = 0 and state holds.

Test Plan:
- Single stamp: requester 2 presents header=H, payload=P, checksum=0xFF in stamp mode with out_ready=1.
  - req_ready=4'b0100 in that cycle.
  - Next cycle out_valid=1, out_flit={H,P,C_model}, out_src=2.
  - The following cycle out_valid=0.
- Round-robin fairness: all 4 requesters valid continuously with out_ready=1.
  - Grants go 0,1,2,3,0,… with one grant per cycle, ptr wraps correctly and out_valid stays 1 every cycle.
- Verify pass/fail: requester 1 sends a flit with checksum=C_model (forwarded unchanged), then the same flit with checksum=C_model^1.
  - Second flit: no out_valid, err_valid pulses one cycle with err_src=1, err_count=1.
- Backpressure: out_ready=0 for 5 cycles with requesters 0 and 3 valid.
  - out_flit is stable and req_ready=0 throughout.
  - On out_ready=1, requester 0 (or ptr order) is accepted the same cycle, then 3 the next.
- Counter saturation and clear with CNT_W=2: 5 bad verify flits.
  - err_count sequence 1,2,3,3,3.
  - err_clr together with a 6th bad flit gives err_count=1.
  - err_clr alone gives 0.
- Reset mid-stream: assert rst while out_valid=1 and ptr=2.
  - Next cycle out_valid=0, err_count=0, req_ready=0.
  - After deassert, the first grant goes to the lowest valid index.
